// File: rtl/stream_demux_pkg.sv
// stream_demux_pkg: default sizes and lane index type shared by the demux slice
package stream_demux_pkg;
   localparam int DEF_N_OUT = 4;
   localparam int DEF_WIDTH = 8;
   typedef logic [$clog2(DEF_N_OUT)-1:0] lane_idx_t;
endpackage

// File: rtl/stream_demux_rr_if.sv
// stream_demux_rr_if: upstream valid/ready port, steering controls and per-lane downstream ports
interface stream_demux_rr_if
   import stream_demux_pkg::*;
#(
   parameter int N_OUT = DEF_N_OUT,
   parameter int WIDTH = DEF_WIDTH
);
   logic                         up_valid;
   logic                         up_ready;
   logic [WIDTH-1:0]             up_data;
   logic                         rr_en;
   logic [$clog2(N_OUT)-1:0]     up_sel;
   logic [N_OUT-1:0]             down_valid;
   logic [N_OUT-1:0]             down_ready;
   logic [N_OUT-1:0][WIDTH-1:0]  down_data;
   logic [$clog2(N_OUT)-1:0]     rr_ptr;
   modport master (
      output up_valid, up_data, rr_en, up_sel, down_ready,
      input  up_ready, down_valid, down_data, rr_ptr
   );
   modport slave (
      input  up_valid, up_data, rr_en, up_sel, down_ready,
      output up_ready, down_valid, down_data, rr_ptr
   );
endinterface

// File: rtl/demux_lane_reg.sv
// demux_lane_reg: one-entry lane register; a load wins over a drain in the same cycle
module demux_lane_reg
   import stream_demux_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic             ready,
   input  logic [WIDTH-1:0] din,
   output logic             full,
   output logic [WIDTH-1:0] dout
);
   logic             full_q, full_d;
   logic [WIDTH-1:0] data_q, data_d;
   always_comb begin
      full_d = load || (full_q && !ready);
      data_d = load ? din : data_q;
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         full_q <= 1'b0;
         data_q <= '0;
      end else begin
         full_q <= full_d;
         data_q <= data_d;
      end
   end
   assign full = full_q;
   assign dout = data_q;
endmodule

// File: rtl/stream_demux_rr.sv
// stream_demux_rr: valid/ready 1-to-N demux steering words by round-robin pointer or explicit select
module stream_demux_rr
   import stream_demux_pkg::*;
#(
   parameter int N_OUT = DEF_N_OUT,
   parameter int WIDTH = DEF_WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   stream_demux_rr_if.slave bus
);
   localparam int IW = $clog2(N_OUT);
   logic [IW-1:0]               rr_ptr_q, rr_ptr_d, tgt;
   logic [N_OUT-1:0]            full, load;
   logic [N_OUT-1:0][WIDTH-1:0] data;
   logic                        acc;
   // ready looks only at the target lane, so it never depends on up_valid
   always_comb begin
      tgt          = bus.rr_en ? rr_ptr_q : bus.up_sel;
      bus.up_ready = !full[tgt] || bus.down_ready[tgt];
      acc          = bus.up_valid && bus.up_ready;
      rr_ptr_d     = (acc && bus.rr_en) ? rr_ptr_q + 1'b1 : rr_ptr_q;
      load         = '0;
      load[tgt]    = acc;
   end
   always_ff @(posedge clk) begin
      if (rst) rr_ptr_q <= '0;
      else     rr_ptr_q <= rr_ptr_d;
   end
   for (genvar g = 0; g < N_OUT; g++) begin : g_lane
      demux_lane_reg #(.WIDTH(WIDTH)) u_lane (
         .clk   (clk),
         .rst   (rst),
         .load  (load[g]),
         .ready (bus.down_ready[g]),
         .din   (bus.up_data),
         .full  (full[g]),
         .dout  (data[g])
      );
   end
   assign bus.down_valid = full;
   assign bus.down_data  = data;
   assign bus.rr_ptr     = rr_ptr_q;
endmodule

// File: doc/stream_demux_rr.md
# stream_demux_rr

Sequential 1-to-N stream demultiplexer: the counterpart of the mux-based selection blocks in the combinational section. It accepts one valid/ready upstream word stream and steers each accepted word into one of N_OUT registered downstream lanes. The lane is either the round-robin pointer or an explicit select. It sits between a single producer and N parallel consumers and absorbs per-lane backpressure with a one-entry register per lane.

## Interface
- N_OUT, 4, number of downstream lanes (≥2, power of two)
- WIDTH, 8, data width in bits
- clk  in  1  system clock, all state on rising edge
- rst  in  1  reset, synchronous and active-high
- up_valid  in  1  upstream word present
- up_ready  out  1  block can accept upstream word this cycle
- up_data  in  WIDTH  upstream word
- rr_en  in  1  1: round-robin steering; 0: steer to up_sel
- up_sel  in  $clog2(N_OUT)  explicit lane, used only when rr_en=0
- down_valid  out  N_OUT  per-lane word present
- down_ready  in  N_OUT  per-lane consumer ready
- down_data  out  N_OUT×WIDTH  packed [N_OUT-1:0][WIDTH-1:0], per-lane word
- rr_ptr  out  $clog2(N_OUT)  current round-robin lane

## Operation
- Target lane tgt = rr_en ? rr_ptr : up_sel (combinational).
- Each lane holds a one-entry register (full bit + data). down_valid[i] = full[i]; down_data[i] = register data.
- up_ready = !full[tgt] || down_ready[tgt]. Pass-through is allowed when the lane drains in the same cycle. up_ready must not depend on up_valid.
- Accept = up_valid && up_ready. On accept, lane tgt loads up_data and stays/becomes full.
- Drain of lane i = full[i] && down_ready[i]. If drained and not loaded that cycle, full[i] ← 0.
- Simultaneous drain and load on the same lane: lane stays full with new data, no word lost or duplicated.
- Lanes are independent. Draining lane j never affects acceptance into lane i≠j.
- rr_ptr advances by 1 modulo N_OUT only on accept with rr_en=1. It holds when rr_en=0 or when there is no accept. Wrap N_OUT-1 → 0.
- up_data is never modified. There is no reordering within a lane.

## Timing
- Reset (rst=1 at clk edge): full all 0, down_valid=0, down_data all 0, rr_ptr=0. up_ready=1 in the first cycle after reset. Reset mid-transfer discards all held words.
- Latency: a word accepted at edge k appears on down_valid/down_data from edge k (visible in cycle k+1). Minimum 1 cycle.
- Throughput: 1 word/cycle sustained when the target lane's consumer is always ready or the pointer rotates across free lanes.
- down_valid[i] and down_data[i] stay stable while down_valid[i]=1 and down_ready[i]=0.
- Stall: when up_valid=1 and up_ready=0, no state changes except drains on other lanes. The producer must hold up_data/up_sel/rr_en.
- rr_en/up_sel changes take effect in the same cycle because they are combinational into tgt.

## Structure
- Package stream_demux_pkg holds the default widths and typedef lane_idx_t (logic [$clog2(N_OUT)-1:0]). The generic package uses localparams for defaults only.
- Sub-module demux_lane_reg: one-entry register with load, drain, full, data, and sync reset. It is instantiated N_OUT times via generate.
- The top level holds tgt selection, the up_ready mux, and the rr_ptr counter.

## Test plan
- Reset then 8 words 0x10..0x17, rr_en=1, all down_ready=1 → lane i receives 0x10+i and then 0x14+i, one word per cycle. up_ready stays 1 and rr_ptr wraps 3→0.
- rr_en=1, down_ready[1]=0, stream 0xA0..0xA5 → 0xA0, 0xA2, 0xA3 go to lanes 0, 2, 3. On 0xA5, aimed at full lane 1, up_ready=0 and it stalls. Raising down_ready[1] drains 0xA1 and accepts 0xA5 in the same cycle.
- rr_en=0, up_sel=2, 3 words 0x01..0x03, down_ready[2] toggling 1/0 → lane 2 outputs 0x01, 0x02, 0x03 in order with no loss. rr_ptr stays 0.
- Lane full with down_ready=1 and a new word targeting it in the same cycle → the old word is consumed, the new word is loaded, and down_valid stays 1 with updated data.
- rst asserted while lanes 0 and 3 are full and up_valid=1 → after the edge, down_valid=0000, rr_ptr=0, and no word is accepted that cycle.
- Random valid/ready over 1000 cycles with a scoreboard per lane → every accepted word is delivered exactly once, in order, with stable data under backpressure.
